// File: rtl/simon_data_pkg.sv
// Shared types and AXI constants for the Simon data-port AXI4 slave.
package simon_data_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [2:0] BEAT_SIZE   = 3'd4;  // log2 of 16-byte beats

  // An address-phase request the streaming window cannot honour.
  function automatic logic bad_addr_phase(input logic [2:0] size, input logic [1:0] burst);
    return (size != BEAT_SIZE) || (burst == BURST_WRAP);
  endfunction

endpackage

// File: rtl/simon_burst_ctr.sv
// Burst beat counter: loads a burst length, counts handshakes, flags the final beat.
module simon_burst_ctr #(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [LEN_WIDTH-1:0] i_len,
  input  logic                 i_step,
  output logic [LEN_WIDTH-1:0] o_cnt,
  output logic                 o_last
);

  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_len <= i_len;
      r_cnt <= '0;
    end else if (i_step && !o_last) begin
      // Holding at the final beat keeps a 256-beat burst from wrapping to 0.
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == r_len);

endmodule

// File: rtl/simon_data_axi_slave.sv
// AXI4 slave streaming window: write bursts feed the cipher's plaintext stream,
// read bursts drain its result stream. Address is ignored beyond protocol checks.
module simon_data_axi_slave
  import simon_data_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk_simon_data,
  input  logic                    simon_data_rstn,

  input  logic [ADDR_WIDTH-1:0]   simon_data_awaddr,
  input  logic [1:0]              simon_data_awburst,
  input  logic [LEN_WIDTH-1:0]    simon_data_awlen,
  input  logic [2:0]              simon_data_awsize,
  input  logic                    simon_data_awvalid,
  output logic                    simon_data_awready,

  input  logic [DATA_WIDTH-1:0]   simon_data_wdata,
  input  logic [DATA_WIDTH/8-1:0] simon_data_wstrb,
  input  logic                    simon_data_wlast,
  input  logic                    simon_data_wvalid,
  output logic                    simon_data_wready,

  output logic [1:0]              simon_data_bresp,
  output logic                    simon_data_bvalid,
  input  logic                    simon_data_bready,

  input  logic [ADDR_WIDTH-1:0]   simon_data_araddr,
  input  logic [1:0]              simon_data_arburst,
  input  logic [LEN_WIDTH-1:0]    simon_data_arlen,
  input  logic [2:0]              simon_data_arsize,
  input  logic                    simon_data_arvalid,
  output logic                    simon_data_arready,

  output logic [DATA_WIDTH-1:0]   simon_data_rdata,
  output logic [1:0]              simon_data_rresp,
  output logic                    simon_data_rlast,
  output logic                    simon_data_rvalid,
  input  logic                    simon_data_rready,

  output logic [DATA_WIDTH-1:0]   blk_in_data,
  output logic                    blk_in_valid,
  input  logic                    blk_in_ready,

  input  logic [DATA_WIDTH-1:0]   blk_out_data,
  input  logic                    blk_out_valid,
  output logic                    blk_out_ready,

  output logic [CNT_WIDTH-1:0]    blk_in_count,
  output logic [CNT_WIDTH-1:0]    blk_out_count
);

  w_state_e               r_wstate;
  r_state_e               r_rstate;
  logic                   r_active;
  logic                   r_werr;
  logic                   r_rerr;
  logic [CNT_WIDTH-1:0]   r_blk_in_count;
  logic [CNT_WIDTH-1:0]   r_blk_out_count;

  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_ar_hs;
  logic                   w_r_hs;
  logic                   w_wlast_beat;
  logic                   w_rlast_beat;
  logic [LEN_WIDTH-1:0]   w_wcnt;
  logic [LEN_WIDTH-1:0]   w_rcnt;
  logic                   w_unused;

  assign w_unused = ^{simon_data_awaddr, simon_data_araddr, w_wcnt, w_rcnt};

  // NOTE: the idle states would raise awready/arready straight out of reset;
  // r_active holds every ready low while reset is asserted.
  always_ff @(posedge clk_simon_data or negedge simon_data_rstn) begin
    if (!simon_data_rstn) r_active <= 1'b0;
    else                  r_active <= 1'b1;
  end

  // Write path: plaintext blocks pass combinationally from W to the engine.
  assign simon_data_awready = r_active && (r_wstate == W_IDLE);
  assign simon_data_wready  = (r_wstate == W_DATA) && blk_in_ready;
  assign blk_in_valid       = (r_wstate == W_DATA) && simon_data_wvalid;
  assign blk_in_data        = simon_data_wdata;
  assign simon_data_bvalid  = (r_wstate == W_RESP);
  assign simon_data_bresp   = (simon_data_bvalid && r_werr) ? RESP_SLVERR : RESP_OKAY;

  assign w_aw_hs = simon_data_awvalid && simon_data_awready;
  assign w_w_hs  = blk_in_valid && blk_in_ready;

  simon_burst_ctr #(.LEN_WIDTH(LEN_WIDTH)) u_wr_ctr (
    .clk    (clk_simon_data),
    .rst_n  (simon_data_rstn),
    .i_load (w_aw_hs),
    .i_len  (simon_data_awlen),
    .i_step (w_w_hs),
    .o_cnt  (w_wcnt),
    .o_last (w_wlast_beat)
  );

  always_ff @(posedge clk_simon_data or negedge simon_data_rstn) begin
    if (!simon_data_rstn) begin
      r_wstate <= W_IDLE;
      r_werr   <= 1'b0;
    end else begin
      unique case (r_wstate)
        W_IDLE: if (w_aw_hs) begin
          r_werr   <= bad_addr_phase(simon_data_awsize, simon_data_awburst);
          r_wstate <= W_DATA;
        end
        W_DATA: if (w_w_hs) begin
          // Malformed beats are still forwarded; they only poison the response.
          if ((simon_data_wstrb != '1) || (simon_data_wlast != w_wlast_beat))
            r_werr <= 1'b1;
          if (w_wlast_beat)
            r_wstate <= W_RESP;
        end
        W_RESP: if (simon_data_bready) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read path: result blocks stay in the engine until an R beat takes them.
  assign simon_data_arready = r_active && (r_rstate == R_IDLE);
  assign simon_data_rvalid  = (r_rstate == R_DATA) && blk_out_valid;
  assign blk_out_ready      = (r_rstate == R_DATA) && simon_data_rready;
  assign simon_data_rdata   = blk_out_data;
  assign simon_data_rlast   = (r_rstate == R_DATA) && w_rlast_beat;
  assign simon_data_rresp   = ((r_rstate == R_DATA) && r_rerr) ? RESP_SLVERR : RESP_OKAY;

  assign w_ar_hs = simon_data_arvalid && simon_data_arready;
  assign w_r_hs  = simon_data_rvalid && simon_data_rready;

  simon_burst_ctr #(.LEN_WIDTH(LEN_WIDTH)) u_rd_ctr (
    .clk    (clk_simon_data),
    .rst_n  (simon_data_rstn),
    .i_load (w_ar_hs),
    .i_len  (simon_data_arlen),
    .i_step (w_r_hs),
    .o_cnt  (w_rcnt),
    .o_last (w_rlast_beat)
  );

  always_ff @(posedge clk_simon_data or negedge simon_data_rstn) begin
    if (!simon_data_rstn) begin
      r_rstate <= R_IDLE;
      r_rerr   <= 1'b0;
    end else begin
      unique case (r_rstate)
        R_IDLE: if (w_ar_hs) begin
          r_rerr   <= bad_addr_phase(simon_data_arsize, simon_data_arburst);
          r_rstate <= R_DATA;
        end
        R_DATA: if (w_r_hs && w_rlast_beat) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_simon_data or negedge simon_data_rstn) begin
    if (!simon_data_rstn) begin
      r_blk_in_count  <= '0;
      r_blk_out_count <= '0;
    end else begin
      if (w_w_hs) r_blk_in_count  <= r_blk_in_count + 1'b1;
      if (w_r_hs) r_blk_out_count <= r_blk_out_count + 1'b1;
    end
  end

  assign blk_in_count  = r_blk_in_count;
  assign blk_out_count = r_blk_out_count;

endmodule

// File: tb/tb_simon_data_axi_slave.sv
// Directed bench for simon_data_axi_slave: write/read bursts, backpressure,
// protocol errors, concurrency and mid-burst reset.
module tb_simon_data_axi_slave;

  localparam int DW = 128;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int CW = 32;

  logic           clk;
  logic           rstn;
  logic [AW-1:0]  awaddr;
  logic [1:0]     awburst;
  logic [LW-1:0]  awlen;
  logic [2:0]     awsize;
  logic           awvalid, awready;
  logic [DW-1:0]  wdata;
  logic [DW/8-1:0] wstrb;
  logic           wlast, wvalid, wready;
  logic [1:0]     bresp;
  logic           bvalid, bready;
  logic [AW-1:0]  araddr;
  logic [1:0]     arburst;
  logic [LW-1:0]  arlen;
  logic [2:0]     arsize;
  logic           arvalid, arready;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast, rvalid, rready;
  logic [DW-1:0]  blk_in_data;
  logic           blk_in_valid, blk_in_ready;
  logic [DW-1:0]  blk_out_data;
  logic           blk_out_valid, blk_out_ready;
  logic [CW-1:0]  blk_in_count, blk_out_count;

  int n_pass  = 0;
  int n_total = 0;
  logic [DW-1:0] in_q[$];

  simon_data_axi_slave dut (
    .clk_simon_data     (clk),
    .simon_data_rstn    (rstn),
    .simon_data_awaddr  (awaddr),
    .simon_data_awburst (awburst),
    .simon_data_awlen   (awlen),
    .simon_data_awsize  (awsize),
    .simon_data_awvalid (awvalid),
    .simon_data_awready (awready),
    .simon_data_wdata   (wdata),
    .simon_data_wstrb   (wstrb),
    .simon_data_wlast   (wlast),
    .simon_data_wvalid  (wvalid),
    .simon_data_wready  (wready),
    .simon_data_bresp   (bresp),
    .simon_data_bvalid  (bvalid),
    .simon_data_bready  (bready),
    .simon_data_araddr  (araddr),
    .simon_data_arburst (arburst),
    .simon_data_arlen   (arlen),
    .simon_data_arsize  (arsize),
    .simon_data_arvalid (arvalid),
    .simon_data_arready (arready),
    .simon_data_rdata   (rdata),
    .simon_data_rresp   (rresp),
    .simon_data_rlast   (rlast),
    .simon_data_rvalid  (rvalid),
    .simon_data_rready  (rready),
    .blk_in_data        (blk_in_data),
    .blk_in_valid       (blk_in_valid),
    .blk_in_ready       (blk_in_ready),
    .blk_out_data       (blk_out_data),
    .blk_out_valid      (blk_out_valid),
    .blk_out_ready      (blk_out_ready),
    .blk_in_count       (blk_in_count),
    .blk_out_count      (blk_out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Blocks reaching the engine, captured mid-cycle where everything is stable.
  always @(negedge clk)
    if (rstn && blk_in_valid && blk_in_ready) in_q.push_back(blk_in_data);

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [LW-1:0] len, input logic [2:0] size, input logic [1:0] burst);
    awvalid = 1'b1; awlen = len; awsize = size; awburst = burst; awaddr = 32'h0000_1000;
    #1 check("awready_idle", awready, 1);
    tick();
    awvalid = 1'b0;
    #1 check("awready_busy", awready, 0);
  endtask

  // Drives beats 1..len+1 as data values; lastbeat/badstrb are 0-based beat indices.
  task automatic wr_burst(input int len, input logic [2:0] size, input int lastbeat,
                          input int badstrb, input bit toggle, input logic [1:0] exp_resp);
    int beat = 0;
    int cyc  = 0;
    in_q.delete();
    do_aw(len[LW-1:0], size, 2'b01);
    while (beat <= len && cyc < 100) begin
      blk_in_ready = toggle ? cyc[0] : 1'b1;
      wvalid = 1'b1;
      wdata  = DW'(beat + 1);
      wlast  = (beat == lastbeat);
      wstrb  = (beat == badstrb) ? 16'h00FF : 16'hFFFF;
      #1;
      check("wready_mirror", wready, blk_in_ready);
      check("bvalid_early", bvalid, 0);
      if (blk_in_ready) beat++;
      tick();
      cyc++;
    end
    wvalid = 1'b0; wlast = 1'b0; blk_in_ready = 1'b1;
    check("burst_done", beat, len + 1);
    #1;
    check("bvalid", bvalid, 1);
    check("bresp", bresp, exp_resp);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    #1 check("bvalid_clear", bvalid, 0);
    check("awready_back", awready, 1);
    check("fwd_blocks", in_q.size(), len + 1);
    for (int i = 0; i < in_q.size(); i++) check("fwd_order", in_q[i], DW'(i + 1));
  endtask

  initial begin
    rstn = 1'b1;
    awaddr = '0; awburst = 2'b01; awlen = '0; awsize = 3'd4; awvalid = 1'b0;
    wdata = '0; wstrb = '1; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arburst = 2'b01; arlen = '0; arsize = 3'd4; arvalid = 1'b0;
    rready = 1'b1; blk_in_ready = 1'b1; blk_out_data = '0; blk_out_valid = 1'b1;
    #1 rstn = 1'b0;
    #2;
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_blk_in_valid", blk_in_valid, 0);
    check("rst_blk_out_ready", blk_out_ready, 0);
    check("rst_resp", {bresp, rresp}, 0);
    check("rst_counts", {blk_in_count, blk_out_count}, 0);
    blk_out_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    tick();
    check("awready_after_rst", awready, 1);
    check("arready_after_rst", arready, 1);

    // Plain 4-beat write, then 8-beat write with toggling engine backpressure.
    wr_burst(3, 3'd4, 3, -1, 1'b0, 2'b00);
    check("in_count_4", blk_in_count, 4);
    wr_burst(7, 3'd4, 7, -1, 1'b1, 2'b00);
    check("in_count_12", blk_in_count, 12);

    // Protocol errors: early wlast, partial strobe, wrong beat size.
    wr_burst(3, 3'd4, 1, -1, 1'b0, 2'b10);
    wr_burst(3, 3'd4, 3, 2, 1'b0, 2'b10);
    wr_burst(3, 3'd3, 3, -1, 1'b0, 2'b10);
    check("in_count_24", blk_in_count, 24);

    // Two-beat read with rready stalled for three cycles on the first beat.
    arvalid = 1'b1; arlen = 8'd1; arsize = 3'd4; arburst = 2'b01;
    #1 check("arready_idle", arready, 1);
    tick();
    arvalid = 1'b0;
    blk_out_valid = 1'b1; blk_out_data = {16{8'hAA}}; rready = 1'b0;
    repeat (3) begin
      #1;
      check("r_stall_rvalid", rvalid, 1);
      check("r_stall_blk_out_ready", blk_out_ready, 0);
      tick();
    end
    rready = 1'b1;
    #1;
    check("r_beat0_data", rdata, {16{8'hAA}});
    check("r_beat0_last", rlast, 0);
    check("r_beat0_resp", rresp, 0);
    tick();
    blk_out_data = {16{8'hBB}};
    #1;
    check("r_beat1_data", rdata, {16{8'hBB}});
    check("r_beat1_last", rlast, 1);
    check("r_beat1_resp", rresp, 0);
    tick();
    #1;
    check("arready_back", arready, 1);
    check("blk_out_ready_idle", blk_out_ready, 0);
    check("out_count_2", blk_out_count, 2);
    blk_out_valid = 1'b0;

    // Simultaneous AW and AR, then reset in the middle of the write burst.
    awvalid = 1'b1; awlen = 8'd3; awsize = 3'd4; awburst = 2'b01;
    arvalid = 1'b1; arlen = 8'd0; arsize = 3'd4; arburst = 2'b01;
    #1;
    check("conc_awready", awready, 1);
    check("conc_arready", arready, 1);
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    blk_out_valid = 1'b1; blk_out_data = {16{8'hCC}}; rready = 1'b1;
    wvalid = 1'b1; wdata = DW'(1); wstrb = '1; wlast = 1'b0; blk_in_ready = 1'b1;
    #1;
    check("conc_busy", {awready, arready}, 2'b00);
    check("conc_rlast", rlast, 1);
    check("conc_blk_in_valid", blk_in_valid, 1);
    tick();
    blk_out_valid = 1'b0;
    wdata = DW'(2);
    tick();
    check("pre_rst_in_count", blk_in_count, 26);
    check("pre_rst_out_count", blk_out_count, 3);
    rstn = 1'b0;
    #1;
    check("mid_rst_readies", {awready, arready, wready, blk_out_ready}, 0);
    check("mid_rst_valids", {bvalid, rvalid, blk_in_valid}, 0);
    check("mid_rst_counts", {blk_in_count, blk_out_count}, 0);
    wvalid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("post_rst_awready", awready, 1);
    check("post_rst_counts", {blk_in_count, blk_out_count}, 0);
    repeat (4) begin
      check("post_rst_no_bvalid", bvalid, 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/simon_data_axi_slave.md
Name: simon_data_axi_slave

Overview:
- AXI4 slave front-end for the Simon data port (128-bit).
- Write bursts are converted into a valid/ready plaintext block stream into the cipher engine; read bursts are sourced from the engine's result block stream.
- Sits directly between the PS data AXI4 master and the Simon cipher datapath, in the simon data clock domain.
- Address is ignored beyond protocol checks: the port is a streaming window.

Parameters:
DATA_WIDTH, 128, AXI data and block width
ADDR_WIDTH, 32, AXI address width
LEN_WIDTH, 8, AXI burst length width
CNT_WIDTH, 32, statistics counter width

Ports:
clk_simon_data  in  1  data-domain clock
simon_data_rstn  in  1  reset, asynchronous assert, active-low
simon_data_aw{addr,burst,len,size,valid}  in  ADDR_WIDTH/2/LEN_WIDTH/3/1  write address channel; cache/lock/prot/qos/region are accepted and ignored
simon_data_awready  out  1  write address ready
simon_data_w{data,strb,last,valid}  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
simon_data_wready  out  1  write data ready
simon_data_b{resp,valid}  out  2/1  write response
simon_data_bready  in  1  write response ready
simon_data_ar{addr,burst,len,size,valid}  in  as AW  read address channel; other AR fields ignored
simon_data_arready  out  1  read address ready
simon_data_r{data,resp,last,valid}  out  DATA_WIDTH/2/1/1  read data channel
simon_data_rready  in  1  read data ready
blk_in_data  out  DATA_WIDTH  plaintext block to engine
blk_in_valid  out  1  plaintext block valid
blk_in_ready  in  1  engine accepts plaintext block
blk_out_data  in  DATA_WIDTH  result block from engine
blk_out_valid  in  1  result block valid
blk_out_ready  out  1  this block accepts result block
blk_in_count  out  CNT_WIDTH  blocks forwarded since reset, wraps
blk_out_count  out  CNT_WIDTH  blocks returned since reset, wraps

Behaviour:
- Clock and reset: one clock, clk_simon_data. Reset simon_data_rstn is asynchronous and active-low.
- Values while reset is asserted: all ready/valid outputs 0; bresp and rresp 0 (OKAY); counters 0.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On awvalid, latch awlen, clear beat counter wcnt, clear err, go to W_DATA.
  - err is set at accept if awsize!=3'd4 or awburst==2'b10 (WRAP).
  - W_DATA: blk_in_valid = wvalid; wready = blk_in_ready; blk_in_data = wdata. This path is combinational, zero latency.
  - Each W handshake increments wcnt and blk_in_count.
  - A beat sets err if wstrb is not all-ones; the beat is still forwarded.
  - A beat sets err if wlast != (wcnt==awlen).
  - The burst ends on the beat where wcnt==awlen regardless of wlast; go to W_RESP.
  - W_RESP: bvalid=1 (registered, the cycle after the final beat); bresp = err ? 2'b10 : 2'b00. Hold until bready, then go to W_IDLE.
  - awready=0 outside W_IDLE, so only one write is outstanding.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On arvalid, latch arlen, clear rcnt, go to R_DATA.
  - rerr is set at accept if arsize!=3'd4 or arburst==2'b10.
  - R_DATA: rvalid = blk_out_valid; blk_out_ready = rready; rdata = blk_out_data; rlast = (rcnt==arlen); rresp = rerr ? 2'b10 : 2'b00.
  - Each R handshake increments rcnt and blk_out_count.
  - A handshake with rlast returns to R_IDLE the next cycle.
  - blk_out_ready=0 in R_IDLE: results are held in the engine until read.
- Read and write FSMs are fully independent. Simultaneous AW and AR in the same cycle are both accepted.
- Burst lengths: awlen=0 means a single beat. Maximum burst is 256 beats. wcnt and rcnt are LEN_WIDTH wide and never wrap within a burst.
- Statistics counters wrap modulo 2^CNT_WIDTH with no saturation.
- Reset mid-burst: FSMs return to idle and partial-burst state is discarded. No response is issued for the aborted transaction.

Decomposition:
- Package simon_data_pkg holds: enums w_state_e and r_state_e; constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, BURST_WRAP=2'b10, BEAT_SIZE=3'd4 (log2 of 16 bytes).
- One sub-module, simon_burst_ctr: loads a len value, counts handshakes, and flags the last beat. Instantiated twice, once for write and once for read.

Test Plan:
- Write burst:
  - Stimulus: AW len=3, size=4, INCR; 4 W beats 0x0..01 to 0x0..04, wlast on beat 4, blk_in_ready=1.
  - Required: blk_in sees 4 blocks in order; bvalid one cycle after beat 4 with bresp=0; blk_in_count=4.
- Backpressure:
  - Stimulus: blk_in_ready toggles every cycle during a len=7 burst.
  - Required: wready mirrors blk_in_ready; all 8 blocks are forwarded exactly once.
- Protocol errors:
  - Stimulus: wlast on beat 2 of a len=3 burst; separately, wstrb=16'h00FF on one beat; separately, awsize=3.
  - Required: every block is forwarded; bresp=2'b10 in each case.
- Read burst:
  - Stimulus: AR len=1; engine supplies 0xAA..AA then 0xBB..BB; rready stalls 3 cycles on beat 1.
  - Required: R beats AA then BB; rlast only on BB; rresp=0; blk_out_count=2.
- Concurrency and reset:
  - Stimulus: AW and AR accepted in the same cycle, both proceed; then assert rstn low mid-write at beat 2 of 4.
  - Required: all ready/valid outputs 0 immediately; after release awready=1, counters 0, no bvalid.
